lcd_status_writer: RTL

- Responder end of the LCDUpdate/LCDAck handshake driven by the reaction-timer FSM.
- Snapshots Cheat/Slow/Wait/ReactionTime on each accepted request, renders a short message on an HD44780-compatible 16x2 character LCD (8-bit bus, write-only), then pulses LCDAck.
- Also runs the LCD power-up initialisation sequence after reset.

---
 rtl/lcd_status_pkg.sv | 109 ++++++++++
 rtl/lcd_status_writer_bin2bcd.sv | 52 +++++
 rtl/lcd_status_writer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_status_pkg.sv
// Shared types, LCD command/character constants and message tables for the
// reaction-timer status writer.
package lcd_status_pkg;

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_CONVERT, S_CLEAR, S_WRITE, S_ACK
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_EHI, PH_SETTLE} phase_t;

    typedef enum logic [1:0] {MSG_CHEAT, MSG_SLOW, MSG_WAIT, MSG_NUM} msg_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;

    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_C     = 8'h43;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_H     = 8'h48;
    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_L     = 8'h4C;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_O     = 8'h4F;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [2:0] LEN_CHEAT = 3'd5;
    localparam logic [2:0] LEN_SLOW  = 3'd4;
    localparam logic [2:0] LEN_WAIT  = 3'd4;
    localparam logic [2:0] LEN_NUM   = 3'd6;

    localparam logic [2:0] INIT_LAST = 3'd4;
    localparam int         BCD_STEPS = 9;

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int cnt_width(input int maxv);
        int w;
        w = $clog2(maxv + 1);
        return (w < 20) ? 20 : w;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return CMD_FUNC_SET;
            3'd2:       return CMD_DISP_ON;
            3'd3:       return CMD_ENTRY;
            default:    return CMD_CLEAR;
        endcase
    endfunction

    function automatic logic [2:0] msg_len(input msg_t m);
        case (m)
            MSG_CHEAT: return LEN_CHEAT;
            MSG_SLOW:  return LEN_SLOW;
            MSG_WAIT:  return LEN_WAIT;
            default:   return LEN_NUM;
        endcase
    endfunction

    function automatic logic [7:0] msg_char(input msg_t m, input logic [2:0] idx,
                                            input logic [3:0] h, input logic [3:0] t,
                                            input logic [3:0] o);
        logic [7:0] c;
        c = CH_SPACE;
        case (m)
            MSG_CHEAT:
                case (idx)
                    3'd0: c = CH_C;
                    3'd1: c = CH_H;
                    3'd2: c = CH_E;
                    3'd3: c = CH_A;
                    default: c = CH_T;
                endcase
            MSG_SLOW:
                case (idx)
                    3'd0: c = CH_S;
                    3'd1: c = CH_L;
                    3'd2: c = CH_O;
                    default: c = CH_W;
                endcase
            MSG_WAIT:
                case (idx)
                    3'd0: c = CH_W;
                    3'd1: c = CH_A;
                    3'd2: c = CH_I;
                    default: c = CH_T;
                endcase
            default:
                case (idx)
                    3'd0: c = CH_ZERO + {4'h0, h};
                    3'd1: c = CH_ZERO + {4'h0, t};
                    3'd2: c = CH_ZERO + {4'h0, o};
                    3'd3: c = CH_SPACE;
                    3'd4: c = CH_M;
                    default: c = CH_S;
                endcase
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_status_writer_bin2bcd.sv
// Sequential double-dabble: 9-bit binary to three BCD digits, done pulses
// exactly BCD_STEPS clocks after start.
module lcd_bin2bcd
    import lcd_status_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic [8:0] bin,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [20:0] sr;
    logic [3:0]  cnt;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [20:0] dabble(input logic [20:0] s);
        logic [20:0] a;
        a = {add3(s[20:17]), add3(s[16:13]), add3(s[12:9]), s[8:0]};
        return {a[19:0], 1'b0};
    endfunction

    // The start edge already performs the first shift, so nine shifts end on the ninth edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sr   <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            sr   <= dabble({12'd0, bin});
            cnt  <= 4'(BCD_STEPS - 1);
            done <= 1'b0;
        end else if (cnt != 4'd0) begin
            sr   <= dabble(sr);
            cnt  <= cnt - 4'd1;
            done <= (cnt == 4'd1);
        end else begin
            done <= 1'b0;
        end
    end

    assign hundreds = sr[20:17];
    assign tens     = sr[16:13];
    assign ones     = sr[12:9];

endmodule

// File: rtl/lcd_status_writer.sv
// Responder for the LCDUpdate/LCDAck handshake: initialises an HD44780 16x2
// display after reset, then renders one status message per request.
module lcd_status_writer
    import lcd_status_pkg::*;
#(
    parameter int E_HIGH_CYC     = 20,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLR_WAIT_CYC   = 82000,
    parameter int PWRUP_WAIT_CYC = 750000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       LCDUpdate,
    input  logic       Cheat,
    input  logic       Slow,
    input  logic       Wait,
    input  logic [8:0] ReactionTime,
    output logic       LCDAck,
    output logic       Busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int EH    = at_least_one(E_HIGH_CYC);
    localparam int CW    = at_least_one(CMD_WAIT_CYC);
    localparam int CLW   = at_least_one(CLR_WAIT_CYC);
    localparam int PW    = at_least_one(PWRUP_WAIT_CYC);
    localparam int MAX01 = (EH > CW) ? EH : CW;
    localparam int MAX23 = (CLW > PW) ? CLW : PW;
    localparam int CNT_W = cnt_width((MAX01 > MAX23) ? MAX01 : MAX23);

    state_t           state;
    phase_t           phase;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] settle_load;
    logic [2:0]       init_idx;
    logic [2:0]       char_idx;
    logic             snap_cheat, snap_slow, snap_wait;
    logic [8:0]       snap_rt;
    logic             bcd_start, bcd_done;
    logic [3:0]       bcd_h, bcd_t, bcd_o;
    msg_t             msg;
    logic [2:0]       len;
    logic             byte_active, byte_done;

    lcd_bin2bcd u_bin2bcd (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (bcd_start),
        .bin      (snap_rt),
        .done     (bcd_done),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o)
    );

    always_comb begin
        msg = MSG_NUM;
        if (snap_cheat)     msg = MSG_CHEAT;
        else if (snap_slow) msg = MSG_SLOW;
        else if (snap_wait) msg = MSG_WAIT;
    end

    assign len         = msg_len(msg);
    assign byte_active = (state == S_INIT) || (state == S_CLEAR) || (state == S_WRITE);
    assign byte_done   = byte_active && (phase == PH_SETTLE) && (cnt == '0);
    // Only the clear-display command needs the long settle; RS/DATA are held so they select it.
    assign settle_load = (!LCD_RS && LCD_DATA == CMD_CLEAR) ? CNT_W'(CLW - 1) : CNT_W'(CW - 1);
    assign LCD_RW      = 1'b0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_PWRUP;
            phase      <= PH_SETUP;
            cnt        <= CNT_W'(PW - 1);
            init_idx   <= '0;
            char_idx   <= '0;
            snap_cheat <= 1'b0;
            snap_slow  <= 1'b0;
            snap_wait  <= 1'b0;
            snap_rt    <= '0;
            bcd_start  <= 1'b0;
            LCDAck     <= 1'b0;
            Busy       <= 1'b1;
            LCD_E      <= 1'b0;
            LCD_RS     <= 1'b0;
            LCD_DATA   <= '0;
        end else begin
            bcd_start <= 1'b0;
            LCDAck    <= 1'b0;

            if (byte_active && !byte_done) begin
                case (phase)
                    PH_SETUP: begin
                        phase <= PH_EHI;
                        LCD_E <= 1'b1;
                        cnt   <= CNT_W'(EH - 1);
                    end
                    PH_EHI: begin
                        if (cnt == '0) begin
                            phase <= PH_SETTLE;
                            LCD_E <= 1'b0;
                            cnt   <= settle_load;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: cnt <= cnt - 1'b1;
                endcase
            end

            case (state)
                S_PWRUP: begin
                    if (cnt == '0) begin
                        state    <= S_INIT;
                        init_idx <= '0;
                        phase    <= PH_SETUP;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= init_cmd(3'd0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_INIT: begin
                    if (byte_done) begin
                        if (init_idx == INIT_LAST) begin
                            state <= S_IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                            phase    <= PH_SETUP;
                            LCD_DATA <= init_cmd(init_idx + 3'd1);
                        end
                    end
                end
                S_IDLE: begin
                    if (LCDUpdate) begin
                        snap_cheat <= Cheat;
                        snap_slow  <= Slow;
                        snap_wait  <= Wait;
                        snap_rt    <= ReactionTime;
                        bcd_start  <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (bcd_done) begin
                        state    <= S_CLEAR;
                        phase    <= PH_SETUP;
                        LCD_RS   <= 1'b0;
                        LCD_DATA <= CMD_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (byte_done) begin
                        state    <= S_WRITE;
                        char_idx <= '0;
                        phase    <= PH_SETUP;
                        LCD_RS   <= 1'b1;
                        LCD_DATA <= msg_char(msg, 3'd0, bcd_h, bcd_t, bcd_o);
                    end
                end
                S_WRITE: begin
                    if (byte_done) begin
                        if (char_idx == len - 3'd1) begin
                            state  <= S_ACK;
                            LCDAck <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 3'd1;
                            phase    <= PH_SETUP;
                            LCD_DATA <= msg_char(msg, char_idx + 3'd1, bcd_h, bcd_t, bcd_o);
                        end
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= S_PWRUP;
                    Busy  <= 1'b1;
                    cnt   <= CNT_W'(PW - 1);
                end
            endcase
        end
    end

endmodule
